digit_scan_mux: RTL and testbench

Parametrised, time-multiplexed N-to-1 digit selector that drives a common-anode multi-digit 7-segment display.
- A prescaler steps a digit index through NUM_DIGITS slots, one slot per REFRESH_DIV clocks.
- Each cycle it forwards the selected digit's raw value and decimal point to the segment decoder, and drives the matching anode line.
- A per-slot dead-time suppresses ghosting.
- Sits between the display data registers and the segment decoder / board pins.

---
 rtl/disp_pkg.sv | 19 +
 rtl/digit_scan_mux_if.sv | 30 +++
 rtl/mod_counter.sv | 27 ++
 rtl/digit_scan_mux.sv | 95 +++++++++
 tb/tb_digit_scan_mux.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared display helpers: anode polarity functions and index-width sizing.
package disp_pkg;

  // 100 MHz board clock / 1 kHz per-digit refresh.
  localparam int DEFAULT_REFRESH_DIV = 100000;

  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic anode_on(input bit active_low);
    return active_low ? 1'b0 : 1'b1;
  endfunction

  function automatic logic anode_off(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/digit_scan_mux_if.sv
// Display data registers on one side, scanned digit/anode drive on the other.
interface digit_scan_mux_if
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 4
);
  localparam int SEL_W = sel_width(NUM_DIGITS);

  logic                         enable;
  logic [NUM_DIGITS*DATA_W-1:0] digits_in;
  logic [NUM_DIGITS-1:0]        dp_in;
  logic [NUM_DIGITS-1:0]        blank_mask;
  logic [DATA_W-1:0]            digit_out;
  logic                         dp_out;
  logic [NUM_DIGITS-1:0]        anode;
  logic [SEL_W-1:0]             digit_sel;
  logic                         scan_tick;

  modport master (
    output enable, digits_in, dp_in, blank_mask,
    input  digit_out, dp_out, anode, digit_sel, scan_tick
  );

  modport slave (
    input  enable, digits_in, dp_in, blank_mask,
    output digit_out, dp_out, anode, digit_sel, scan_tick
  );

endinterface

// File: rtl/mod_counter.sv
// Modulo-MODULUS up-counter with a wrap strobe on its last enabled count.
// Latency: count updates on the clock after en; wrap is combinational.
// Backpressure: none; en simply holds the count.
module mod_counter
  import disp_pkg::*;
#(
  parameter  int MODULUS = 4,
  localparam int W       = sel_width(MODULUS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == W'(MODULUS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed digit selector for a common-anode 7-segment display.
// Latency: all outputs registered, one cycle after the (cnt, idx, inputs) they reflect.
// Backpressure: none; enable=0 freezes the scan and darkens every anode.
module digit_scan_mux
  import disp_pkg::*;
#(
  parameter  int NUM_DIGITS       = 4,
  parameter  int DATA_W           = 4,
  parameter  int REFRESH_DIV      = DEFAULT_REFRESH_DIV,
  parameter  int BLANK_CYCLES     = 16,
  parameter  bit ANODE_ACTIVE_LOW = 1'b1,
  localparam int SEL_W            = sel_width(NUM_DIGITS)
) (
  input  logic            clk,
  input  logic            reset,
  digit_scan_mux_if.slave scan
);

  localparam int CNT_W = sel_width(REFRESH_DIV);

  logic [CNT_W-1:0]      cnt;
  logic                  cnt_wrap;
  logic [SEL_W-1:0]      idx;
  logic                  idx_wrap;
  logic                  past_blank;
  logic                  lit;
  logic [DATA_W-1:0]     sel_dig;
  logic                  sel_dp;
  logic                  sel_blank;
  logic [NUM_DIGITS-1:0] anode_nxt;

  mod_counter #(.MODULUS(REFRESH_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (scan.enable),
    .count (cnt),
    .wrap  (cnt_wrap)
  );

  // idx_wrap fires only on the last clock of the last slot, i.e. frame end.
  mod_counter #(.MODULUS(NUM_DIGITS)) u_digit_idx (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_wrap & scan.enable),
    .count (idx),
    .wrap  (idx_wrap)
  );

  if (BLANK_CYCLES == 0) begin : g_no_dead
    assign past_blank = 1'b1;
  end else begin : g_dead
    assign past_blank = (cnt >= CNT_W'(BLANK_CYCLES));
  end

  always_comb begin
    sel_dig   = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == SEL_W'(i)) begin
        sel_dig   = scan.digits_in[i*DATA_W +: DATA_W];
        sel_dp    = scan.dp_in[i];
        sel_blank = scan.blank_mask[i];
      end
    end
  end

  assign lit = scan.enable & ~sel_blank & past_blank;

  always_comb begin
    anode_nxt = {NUM_DIGITS{anode_off(ANODE_ACTIVE_LOW)}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit && (idx == SEL_W'(i))) begin
        anode_nxt[i] = anode_on(ANODE_ACTIVE_LOW);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan.digit_out <= '0;
      scan.dp_out    <= 1'b0;
      scan.anode     <= {NUM_DIGITS{anode_off(ANODE_ACTIVE_LOW)}};
      scan.digit_sel <= '0;
      scan.scan_tick <= 1'b0;
    end else begin
      scan.digit_out <= lit ? sel_dig : '0;
      scan.dp_out    <= lit & sel_dp;
      scan.anode     <= anode_nxt;
      scan.digit_sel <= idx;
      scan.scan_tick <= idx_wrap;
    end
  end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Scoreboard bench: two configurations (4 digits / dead-time, 3 digits / none) vs a time-based model.
module tb_digit_scan_mux;

  typedef struct packed {
    logic [3:0] digit;
    logic       dp;
    logic [3:0] anode;
    logic [1:0] sel;
    logic       tick;
  } obs_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  digit_scan_mux_if #(.NUM_DIGITS(4), .DATA_W(4)) ifa ();
  digit_scan_mux_if #(.NUM_DIGITS(3), .DATA_W(4)) ifb ();

  digit_scan_mux #(.NUM_DIGITS(4), .DATA_W(4), .REFRESH_DIV(4), .BLANK_CYCLES(1),
                   .ANODE_ACTIVE_LOW(1'b1)) dut_a (.clk(clk), .reset(rst_a), .scan(ifa));
  digit_scan_mux #(.NUM_DIGITS(3), .DATA_W(4), .REFRESH_DIV(2), .BLANK_CYCLES(0),
                   .ANODE_ACTIVE_LOW(1'b1)) dut_b (.clk(clk), .reset(rst_b), .scan(ifb));

  obs_t qa[$];
  obs_t qb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   ta = 0;   // enabled clocks since reset, modulo one frame
  int   tb = 0;

  // Position in the scan is derived from elapsed enabled time: slot = t / div.
  function automatic obs_t ref_out(input int n, input int rd, input int blank, input int t,
                                   input logic rst, input logic en, input logic [15:0] digs,
                                   input logic [3:0] dps, input logic [3:0] bm);
    obs_t o;
    int   cnt;
    int   idx;
    o = '{digit: 4'h0, dp: 1'b0, anode: 4'hF, sel: 2'd0, tick: 1'b0};
    if (rst) return o;
    cnt   = t % rd;
    idx   = (t / rd) % n;
    o.sel = 2'(idx);
    o.tick = en && (cnt == rd - 1) && (idx == n - 1);
    if (en && !bm[idx] && cnt >= blank) begin
      o.digit      = digs[idx*4 +: 4];
      o.dp         = dps[idx];
      o.anode[idx] = 1'b0;
    end
    return o;
  endfunction

  task automatic step_a(input logic rst, input logic en, input logic [15:0] digs,
                        input logic [3:0] dps, input logic [3:0] bm);
    @(negedge clk);
    rst_a = rst; ifa.enable = en; ifa.digits_in = digs; ifa.dp_in = dps; ifa.blank_mask = bm;
    qa.push_back(ref_out(4, 4, 1, ta, rst, en, digs, dps, bm));
    if (rst) ta = 0;
    else if (en) ta = (ta + 1) % 16;
  endtask

  task automatic step_b(input logic rst, input logic en, input logic [11:0] digs,
                        input logic [2:0] dps, input logic [2:0] bm);
    @(negedge clk);
    rst_b = rst; ifb.enable = en; ifb.digits_in = digs; ifb.dp_in = dps; ifb.blank_mask = bm;
    qb.push_back(ref_out(3, 2, 0, tb, rst, en, {4'h0, digs}, {1'b0, dps}, {1'b0, bm}));
    if (rst) tb = 0;
    else if (en) tb = (tb + 1) % 6;
  endtask

  task automatic drive_a();
    logic [15:0] d;
    int          guard;
    d = 16'h4321;
    repeat (2) step_a(1'b1, 1'b1, d, 4'b0100, 4'b0000);
    repeat (40) step_a(1'b0, 1'b1, d, 4'b0100, 4'b0000);
    repeat (20) step_a(1'b0, 1'b1, d, 4'b0100, 4'b0010);
    // freeze mid-slot of digit 2 (cnt=2)
    guard = 0;
    while (ta != 10 && guard < 32) begin
      step_a(1'b0, 1'b1, d, 4'b0100, 4'b0000);
      guard++;
    end
    repeat (10) step_a(1'b0, 1'b0, d, 4'b0100, 4'b0000);
    repeat (10) step_a(1'b0, 1'b1, d, 4'b0100, 4'b0000);
    // reset while digit 3 is lit
    guard = 0;
    while (ta != 13 && guard < 32) begin
      step_a(1'b0, 1'b1, d, 4'b0100, 4'b0000);
      guard++;
    end
    step_a(1'b1, 1'b1, d, 4'b0100, 4'b0000);
    repeat (8) step_a(1'b0, 1'b1, d, 4'b0100, 4'b0000);
    // live update of digit 1 mid-slot
    guard = 0;
    while (ta != 6 && guard < 32) begin
      step_a(1'b0, 1'b1, d, 4'b0100, 4'b0000);
      guard++;
    end
    d[7:4] = 4'h9;
    repeat (6) step_a(1'b0, 1'b1, d, 4'b0100, 4'b0000);
    for (int i = 0; i < 400; i++) begin
      step_a(($urandom % 50) == 0, ($urandom % 8) != 0, 16'($urandom), 4'($urandom),
             (($urandom % 4) == 0) ? 4'($urandom) : 4'b0000);
    end
  endtask

  task automatic drive_b();
    step_b(1'b1, 1'b0, 12'h000, 3'b000, 3'b000);
    repeat (30) step_b(1'b0, 1'b1, 12'h765, 3'b001, 3'b000);
    for (int i = 0; i < 300; i++) begin
      step_b(($urandom % 40) == 0, ($urandom % 6) != 0, 12'($urandom), 3'($urandom),
             (($urandom % 4) == 0) ? 3'($urandom) : 3'b000);
    end
  endtask

  initial begin : mon_a
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        a = '{digit: ifa.digit_out, dp: ifa.dp_out, anode: ifa.anode,
              sel: ifa.digit_sel, tick: ifa.scan_tick};
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL dut_a @%0t got digit=%h dp=%b anode=%b sel=%0d tick=%b, want digit=%h dp=%b anode=%b sel=%0d tick=%b",
                   $time, a.digit, a.dp, a.anode, a.sel, a.tick, e.digit, e.dp, e.anode, e.sel, e.tick);
        end
      end
    end
  end

  initial begin : mon_b
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (qb.size() > 0) begin
        e = qb.pop_front();
        a = '{digit: ifb.digit_out, dp: ifb.dp_out, anode: {1'b1, ifb.anode},
              sel: ifb.digit_sel, tick: ifb.scan_tick};
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL dut_b @%0t got digit=%h dp=%b anode=%b sel=%0d tick=%b, want digit=%h dp=%b anode=%b sel=%0d tick=%b",
                   $time, a.digit, a.dp, a.anode, a.sel, a.tick, e.digit, e.dp, e.anode, e.sel, e.tick);
        end
      end
    end
  end

  initial begin
    ifa.enable = 1'b0; ifa.digits_in = '0; ifa.dp_in = '0; ifa.blank_mask = '0;
    ifb.enable = 1'b0; ifb.digits_in = '0; ifb.dp_in = '0; ifb.blank_mask = '0;
    fork
      drive_a();
      drive_b();
    join
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending a=%0d b=%0d, want 0 0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
